tx: RTL

TX -- requirements
Module: tx

---
 rtl/async_pkg.sv | 19 +
 rtl/tx_if.sv | 24 ++
 rtl/tx_baud_gen.sv | 34 +++
 rtl/tx.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/async_pkg.sv
// async_pkg: definitions shared by the asynchronous serial transmitter and receiver.
// Revision 1.0 - initial release.
`default_nettype none

package async_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  localparam int unsigned DEFAULT_CLKS_PER_BIT = 8;
  localparam int unsigned FRAME_BITS           = 8;

endpackage

`default_nettype wire

// File: rtl/tx_if.sv
// tx_if: parallel-load / serial-out handshake bundle of the transmitter.
// Revision 1.0 - initial release.
`default_nettype none

interface tx_if;
  logic [7:0] tx_pi;
  logic       tx_load;
  logic       tx_so;
  logic       tx_ready;
  logic       tx_busy;
  logic       tx_done;

  modport master (
    output tx_pi, tx_load,
    input  tx_so, tx_ready, tx_busy, tx_done
  );

  modport slave (
    input  tx_pi, tx_load,
    output tx_so, tx_ready, tx_busy, tx_done
  );
endinterface

`default_nettype wire

// File: rtl/tx_baud_gen.sv
// tx_baud_gen: loadable bit-period down-counter with a one-cycle bit_end strobe.
// Revision 1.0 - initial release.
`default_nettype none

module tx_baud_gen #(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_load,
  output logic o_bit_end
);

  localparam int            c_cnt_w  = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [c_cnt_w-1:0] c_reload = c_cnt_w'(CLKS_PER_BIT - 1);

  logic [c_cnt_w-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= c_reload;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_bit_end = i_en && (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/tx.sv
// tx: 8N1 serial transmitter, MSB first, CLKS_PER_BIT clocks per bit.
// Optional macro TX_BUF_EN adds a one-byte holding register for gap-free frames. Revision 1.0.
`default_nettype none

module tx
  import async_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  tx_if.slave  bus
);

  localparam int                c_idx_w    = $clog2(FRAME_BITS);
  localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(FRAME_BITS - 1);

  uart_state_t             r_state;
  logic                    r_so;
  logic                    r_busy;
  logic                    r_done;
  logic [FRAME_BITS-1:0]   r_shreg;
  logic [c_idx_w-1:0]      r_bit_idx;

  logic                    w_bit_end;
  logic                    w_ready;
  logic                    w_accept;
  logic                    w_start;
  logic [FRAME_BITS-1:0]   w_start_data;

`ifdef TX_BUF_EN
  logic                    r_hold_valid;
  logic [FRAME_BITS-1:0]   r_hold;
  logic                    w_to_hold;

  assign w_ready = !r_hold_valid;
`else
  assign w_ready = (r_state == IDLE) && !rst;
`endif

  assign w_accept = bus.tx_load && w_ready;

  // A new frame starts from IDLE, or straight out of STOP when a byte is waiting.
  always_comb begin
    w_start      = 1'b0;
    w_start_data = bus.tx_pi;
`ifdef TX_BUF_EN
    w_to_hold    = 1'b0;
`endif
    case (r_state)
      IDLE: w_start = w_accept;
      STOP: begin
`ifdef TX_BUF_EN
        if (w_bit_end) begin
          if (r_hold_valid) begin
            w_start      = 1'b1;
            w_start_data = r_hold;
            w_to_hold    = w_accept;
          end else begin
            w_start = w_accept;
          end
        end else begin
          w_to_hold = w_accept;
        end
`endif
      end
      default: begin
`ifdef TX_BUF_EN
        w_to_hold = w_accept;
`endif
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_so      <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_shreg   <= '0;
      r_bit_idx <= '0;
    end else begin
      r_done <= (r_state == STOP) && w_bit_end;
      if (w_start) begin
        r_state <= START;
        r_so    <= 1'b0;
        r_busy  <= 1'b1;
        r_shreg <= w_start_data;
      end else begin
        case (r_state)
          START: if (w_bit_end) begin
            r_state   <= DATA;
            r_so      <= r_shreg[FRAME_BITS-1];
            r_shreg   <= {r_shreg[FRAME_BITS-2:0], 1'b0};
            r_bit_idx <= c_last_idx;
          end
          DATA: if (w_bit_end) begin
            if (r_bit_idx == '0) begin
              r_state <= STOP;
              r_so    <= 1'b1;
            end else begin
              r_bit_idx <= r_bit_idx - 1'b1;
              r_so      <= r_shreg[FRAME_BITS-1];
              r_shreg   <= {r_shreg[FRAME_BITS-2:0], 1'b0};
            end
          end
          STOP: if (w_bit_end) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef TX_BUF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold_valid <= 1'b0;
      r_hold       <= '0;
    end else if (w_to_hold) begin
      r_hold_valid <= 1'b1;
      r_hold       <= bus.tx_pi;
    end else if (w_start && (r_state == STOP)) begin
      r_hold_valid <= 1'b0;
    end
  end
`endif

  tx_baud_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk       (clk),
    .rst       (rst),
    .i_en      (r_busy),
    .i_load    (w_start || w_bit_end),
    .o_bit_end (w_bit_end)
  );

  assign bus.tx_so    = r_so;
  assign bus.tx_busy  = r_busy;
  assign bus.tx_done  = r_done;
  assign bus.tx_ready = w_ready;

endmodule

`default_nettype wire
